// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared constants for the 640x480@60 scan-out path: porch/sync widths,
// line/frame totals, counter boundary values, the RGB444 pixel type and
// the eight colour-bar constants with a helper that picks the bar for a column.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_ACT_END = cnt_t'(H_ACTIVE);
  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t HS_START  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END    = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t V_ACT_END = cnt_t'(V_ACTIVE);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t VS_START  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END    = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] pixel_t;

  localparam int     BAR_W       = 80;
  localparam pixel_t BAR_WHITE   = 12'hFFF;
  localparam pixel_t BAR_YELLOW  = 12'hFF0;
  localparam pixel_t BAR_CYAN    = 12'h0FF;
  localparam pixel_t BAR_GREEN   = 12'h0F0;
  localparam pixel_t BAR_MAGENTA = 12'hF0F;
  localparam pixel_t BAR_RED     = 12'hF00;
  localparam pixel_t BAR_BLUE    = 12'h00F;
  localparam pixel_t BAR_BLACK   = 12'h000;

  // Bar index found by threshold compares so no divider is built.
  function automatic pixel_t bar_colour(input cnt_t h);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < 8; i++)
      if (h >= cnt_t'(i * BAR_W)) idx = 3'(i);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Horizontal/vertical raster counters for 640x480@60 with active-area and
// sync decode. All decode outputs are combinational from the counters.
// Ports: clk, rst_n (async active-low), en (low holds counters at 0,0),
//        h_cnt/v_cnt (raster position), h_last (last pixel of line),
//        active (visible area), hsync/vsync (level SYNC_POL inside pulse).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             h_last,
  output logic             active,
  output logic             hsync,
  output logic             vsync
);

  assign h_last = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      // Dropping en abandons the frame; the next enable starts at (0,0).
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  assign active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync  = (h_cnt >= HS_START && h_cnt <= HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync  = (v_cnt >= VS_START && v_cnt <= VS_END) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout
// Read side of the 320x240 RGB444 framebuffer. Generates 640x480@60 timing,
// reads the framebuffer with 2x pixel and 2x line replication, and emits an
// aligned hsync/vsync/de/rgb/frame_start stream two clocks after the counters.
// Ports: clk (pixel/read clock), rst_n (async active-low), en (scan enable),
//        test_sel (colour bars, FB_SCANOUT_TESTPAT_EN builds only),
//        fb_en_rd/fb_addr_rd (read port, combinational), fb_dout (data, +1 clk),
//        hsync, vsync, de, rgb, frame_start (registered video out).
// Build option: define FB_SCANOUT_TESTPAT_EN to include the colour-bar source.
module fb_scanout
  import video_timing_pkg::*;
#(
  parameter int   FB_WIDTH   = 320,
  parameter int   ADDR_WIDTH = 17,
  parameter int   DATA_WIDTH = 12,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  test_sel,
  output logic                  fb_en_rd,
  output logic [ADDR_WIDTH-1:0] fb_addr_rd,
  input  logic [DATA_WIDTH-1:0] fb_dout,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  frame_start
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, active, hs_c, vs_c;

  video_timing_gen #(.SYNC_POL(SYNC_POL)) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .h_last (h_last),
    .active (active),
    .hsync  (hs_c),
    .vsync  (vs_c)
  );

  logic tp_sel;
`ifdef FB_SCANOUT_TESTPAT_EN
  assign tp_sel = test_sel;
`else
  logic unused_test_sel;
  assign tp_sel          = 1'b0;
  assign unused_test_sel = test_sel;
`endif

  // Start address of the current framebuffer row. It advances after every
  // odd visible line, so each row is fetched for two output lines.
  logic [ADDR_WIDTH-1:0] line_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
    end else if (!en) begin
      line_base <= '0;
    end else if (h_last) begin
      if (v_cnt == V_LAST)
        line_base <= '0;
      else if (v_cnt[0] && v_cnt < V_ACT_END)
        line_base <= line_base + ADDR_WIDTH'(FB_WIDTH);
    end
  end

  // ---- stage p0: read request from counter state ----
  // rst_n gates the enable so nothing is read while reset is held.
  assign fb_en_rd   = active & en & rst_n & ~tp_sel;
  assign fb_addr_rd = active ? line_base + ADDR_WIDTH'(h_cnt >> 1) : '0;

  // ---- stage p1: control aligned with framebuffer data ----
  logic vld_p1, hs_p1, vs_p1, fs_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= ~SYNC_POL;
      vs_p1  <= ~SYNC_POL;
      fs_p1  <= 1'b0;
    end else if (!en) begin
      vld_p1 <= 1'b0;
      hs_p1  <= ~SYNC_POL;
      vs_p1  <= ~SYNC_POL;
      fs_p1  <= 1'b0;
    end else begin
      vld_p1 <= active;
      hs_p1  <= hs_c;
      vs_p1  <= vs_c;
      fs_p1  <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  logic [DATA_WIDTH-1:0] pix_p1;
`ifdef FB_SCANOUT_TESTPAT_EN
  logic                  tp_p1;
  logic [DATA_WIDTH-1:0] bar_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tp_p1 <= 1'b0;
    else if (!en) tp_p1 <= 1'b0;
    else          tp_p1 <= test_sel;
  end

  // Bar colour is only consumed when vld_p1 and tp_p1 are set, so no reset.
  always_ff @(posedge clk) begin
    bar_p1 <= DATA_WIDTH'(bar_colour(h_cnt));
  end

  assign pix_p1 = tp_p1 ? bar_p1 : fb_dout;
`else
  assign pix_p1 = fb_dout;
`endif

  // ---- stage p2: registered video outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_p1;
      vsync       <= vs_p1;
      de          <= vld_p1;
      rgb         <= vld_p1 ? pix_p1 : '0;
      frame_start <= fs_p1;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout
// Bench for fb_scanout: framebuffer model with one-cycle read latency filled
// with random pixels, a raster-position reference model, an address table,
// and hand-written sequences for reset, enable restart and sync widths.
module tb_fb_scanout;

  localparam int H_TOT = 800;
  localparam int V_TOT = 525;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
`ifdef FB_SCANOUT_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, test_sel;
  logic        fb_en_rd;
  logic [16:0] fb_addr_rd;
  logic [11:0] fb_dout;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .test_sel    (test_sel),
    .fb_en_rd    (fb_en_rd),
    .fb_addr_rd  (fb_addr_rd),
    .fb_dout     (fb_dout),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  logic [11:0] fbmem [FB_W*FB_H];

  always @(posedge clk)
    if (fb_en_rd) fb_dout <= fbmem[fb_addr_rd];

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] rgb;
  } vout_t;

  typedef struct {
    int v;
    int h;
    int addr;
    bit rd;
  } row_t;

  localparam int NTBL = 14;
  row_t tbl [NTBL];

  int    n_vec, n_bad;
  int    pos;           // raster position of the DUT counters, p = v*800 + h
  vout_t p_exp, o_exp;  // expected contents one and two clocks downstream

  function automatic vout_t idle_out();
    vout_t r;
    r    = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  function automatic bit ref_act(int p);
    return ((p % H_TOT) < 640) && ((p / H_TOT) < 480);
  endfunction

  function automatic int ref_addr(int p);
    if (!ref_act(p)) return 0;
    return ((p / H_TOT) / 2) * FB_W + (p % H_TOT) / 2;
  endfunction

  function automatic logic [11:0] bar_ref(int h);
    case (h / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic vout_t ref_out(int p, logic sel);
    vout_t r;
    int h, v;
    h     = p % H_TOT;
    v     = p / H_TOT;
    r.de  = ref_act(p);
    r.hs  = !(h >= 656 && h <= 751);
    r.vs  = !(v >= 490 && v <= 491);
    r.fs  = (p == 0);
    r.rgb = 12'h000;
    if (r.de) r.rgb = (TP && sel) ? bar_ref(h) : fbmem[ref_addr(p)];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input vout_t e);
    check({tag, ".hsync"},       32'(hsync),       32'(e.hs));
    check({tag, ".vsync"},       32'(vsync),       32'(e.vs));
    check({tag, ".de"},          32'(de),          32'(e.de));
    check({tag, ".frame_start"}, 32'(frame_start), 32'(e.fs));
    check({tag, ".rgb"},         32'(rgb),         32'(e.rgb));
  endtask

  // One clock: read port checked before the edge, video outputs after it.
  task automatic step();
    #1;
    check("fb_en_rd",   32'(fb_en_rd),   32'(en && rst_n && ref_act(pos) && !(TP && test_sel)));
    check("fb_addr_rd", 32'(fb_addr_rd), 32'(ref_addr(pos)));
    @(posedge clk);
    if (!rst_n || !en) begin
      pos   = 0;
      p_exp = idle_out();
      o_exp = idle_out();
    end else begin
      o_exp = p_exp;
      p_exp = ref_out(pos, test_sel);
      pos   = (pos + 1) % FRAME;
    end
    @(negedge clk);
    check_out("out", o_exp);
  endtask

  initial begin
    int lowcnt, per, guard;

    for (int i = 0; i < FB_W*FB_H; i++) fbmem[i] = 12'($urandom);

    tbl[0]  = '{v: 0,  h: 0,   addr: 0,    rd: 1'b1};
    tbl[1]  = '{v: 0,  h: 1,   addr: 0,    rd: 1'b1};
    tbl[2]  = '{v: 0,  h: 2,   addr: 1,    rd: 1'b1};
    tbl[3]  = '{v: 0,  h: 639, addr: 319,  rd: 1'b1};
    tbl[4]  = '{v: 0,  h: 640, addr: 0,    rd: 1'b0};
    tbl[5]  = '{v: 1,  h: 0,   addr: 0,    rd: 1'b1};
    tbl[6]  = '{v: 1,  h: 638, addr: 319,  rd: 1'b1};
    tbl[7]  = '{v: 2,  h: 0,   addr: 320,  rd: 1'b1};
    tbl[8]  = '{v: 3,  h: 1,   addr: 320,  rd: 1'b1};
    tbl[9]  = '{v: 3,  h: 639, addr: 639,  rd: 1'b1};
    tbl[10] = '{v: 4,  h: 0,   addr: 640,  rd: 1'b1};
    tbl[11] = '{v: 7,  h: 100, addr: 1010, rd: 1'b1};
    tbl[12] = '{v: 9,  h: 700, addr: 0,    rd: 1'b0};
    tbl[13] = '{v: 12, h: 320, addr: 2080, rd: 1'b1};

    n_vec = 0;
    n_bad = 0;
    pos   = 0;
    p_exp = idle_out();
    o_exp = idle_out();
    rst_n = 1'b0;
    en    = 1'b0;
    test_sel = 1'b0;

    // Reset state, including en high while reset is still held.
    @(negedge clk);
    check_out("reset", idle_out());
    check("reset.fb_en_rd",   32'(fb_en_rd),   32'd0);
    check("reset.fb_addr_rd", 32'(fb_addr_rd), 32'd0);
    en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b0;
    step();
    step();

    // Address table over the first lines of a frame.
    en = 1'b1;
    for (int k = 0; k < NTBL; k++) begin
      while (pos < tbl[k].v * H_TOT + tbl[k].h) step();
      #1;
      check($sformatf("tbl%0d.addr", k), 32'(fb_addr_rd), 32'(tbl[k].addr));
      check($sformatf("tbl%0d.rd", k),   32'(fb_en_rd),   32'(tbl[k].rd));
    end

    // Enable dropped mid-line for 10 clocks, then a clean restart.
    while (pos < 13 * H_TOT + 300) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("endrop.de",       32'(de),       32'd0);
      check("endrop.fb_en_rd", 32'(fb_en_rd), 32'd0);
    end
    en = 1'b1;
    #1;
    check("restart.fb_addr_rd", 32'(fb_addr_rd), 32'd0);
    check("restart.fb_en_rd",   32'(fb_en_rd),   32'd1);
    step();
    check("lat1.frame_start", 32'(frame_start), 32'd0);
    check("lat1.de",          32'(de),          32'd0);
    step();
    check("lat2.frame_start", 32'(frame_start), 32'd1);
    check("lat2.de",          32'(de),          32'd1);
    check("lat2.rgb",         32'(rgb),         32'(fbmem[0]));
    step();
    check("lat3.frame_start", 32'(frame_start), 32'd0);
    check("lat3.rgb",         32'(rgb),         32'(fbmem[0]));
    step();
    check("lat4.rgb",         32'(rgb),         32'(fbmem[1]));

    // hsync pulse width and period measured on the output pin.
    guard = 0;
    while (hsync !== 1'b0 && guard < 2000) begin step(); guard++; end
    lowcnt = 0;
    while (hsync === 1'b0 && lowcnt < 2000) begin step(); lowcnt++; end
    check("hsync_low_width", 32'(lowcnt), 32'd96);
    per = lowcnt;
    while (hsync !== 1'b0 && per < 2000) begin step(); per++; end
    check("hsync_period", 32'(per), 32'd800);

`ifdef FB_SCANOUT_TESTPAT_EN
    // Colour bars from a fresh frame start.
    en = 1'b0;
    step();
    en       = 1'b1;
    test_sel = 1'b1;
    step();
    step();
    check("bar.px0",      32'(rgb),      32'h0FFF);
    check("bar.fb_en_rd", 32'(fb_en_rd), 32'd0);
    repeat (80) step();
    check("bar.px80",     32'(rgb),      32'h0FF0);
    repeat (559) step();
    check("bar.px639",    32'(rgb),      32'h0000);
    check("bar.de639",    32'(de),       32'd1);
    test_sel = 1'b0;
`endif

    // Randomised run with occasional enable drops and one asynchronous reset.
    for (int i = 0; i < 40000; i++) begin
      test_sel = 1'($urandom);
      en       = ($urandom_range(0, 3999) != 0);
      if (i == 20000) begin
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", idle_out());
        check("async_rst.fb_en_rd", 32'(fb_en_rd), 32'd0);
        pos   = 0;
        p_exp = idle_out();
        o_exp = idle_out();
        step();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
